// File: rtl/lcd_scanout_if.sv
// FIFO read port between the pixel FIFO and lcd_scanout.
// The scanout pops the FIFO, so it is the master of this port.
interface lcd_scanout_if;
  logic        fifo_rd;
  logic [31:0] fifo_data;
  logic        fifo_empty;

  modport master (output fifo_rd, input fifo_data, input fifo_empty);
  modport slave  (input fifo_rd, output fifo_data, output fifo_empty);
endinterface

// File: rtl/lcd_scanout.sv
// LCD scan-out for the pixel FIFO: 800x480 timing, one 32-bit word popped per 4 pixels, RGB332 to RGB565.
// Optional build macro LCD_TEST_PATTERN_EN adds i_Test_Pattern (vertical bars from h[9:2], no FIFO pops).
module lcd_scanout #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_First_Data_Ready,
`ifdef LCD_TEST_PATTERN_EN
  input  logic          i_Test_Pattern,
`endif
  lcd_scanout_if.master fifo,
  output logic          o_LCD_HSync,
  output logic          o_LCD_VSync,
  output logic          o_LCD_DE,
  output logic [4:0]    o_LCD_R,
  output logic [5:0]    o_LCD_G,
  output logic [4:0]    o_LCD_B,
  output logic          o_Underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // At least 10 bits so h[9:2] always exists for the test pattern.
  localparam int HW = ($clog2(H_TOTAL) < 10) ? 10 : $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT     = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_LO = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_HI = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT     = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_LO = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_HI = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {S_WAIT, S_RUN} state_t;

  state_t          state_reg, state_next;
  logic [HW-1:0]   h_reg;
  logic [VW-1:0]   v_reg;
  logic            tp_en;
  logic            run, de0, hs0, vs0, slot0, rd0, underflow0;

  logic            de1_reg, hs1_reg, vs1_reg, slot1_reg, rd1_reg, tp1_reg;
  logic [7:0]      tp_byte1_reg;
  logic [31:0]     shift_reg;
  logic            grp_ok_reg;
  logic [7:0]      pix_byte;
  logic            pix_ok;

`ifdef LCD_TEST_PATTERN_EN
  assign tp_en = i_Test_Pattern;
`else
  assign tp_en = 1'b0;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_reg <= S_WAIT;
    else          state_reg <= state_next;
  end

  // Stage 0: next state plus everything decoded straight from the counters.
  always_comb begin
    state_next = state_reg;
    if (state_reg == S_WAIT && i_First_Data_Ready) state_next = S_RUN;
    run        = (state_reg == S_RUN);
    de0        = run && (h_reg < H_ACT) && (v_reg < V_ACT);
    hs0        = !(run && (h_reg >= H_SYNC_LO) && (h_reg < H_SYNC_HI));
    vs0        = !(run && (v_reg >= V_SYNC_LO) && (v_reg < V_SYNC_HI));
    slot0      = de0 && (h_reg[1:0] == 2'b00);
    rd0        = slot0 && !tp_en && !fifo.fifo_empty;
    underflow0 = slot0 && !tp_en && fifo.fifo_empty;
  end

  assign fifo.fifo_rd = rd0;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (run) begin
      if (h_reg == H_LAST) begin
        h_reg <= '0;
        v_reg <= (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
      end else begin
        h_reg <= h_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      de1_reg      <= 1'b0;
      hs1_reg      <= 1'b1;
      vs1_reg      <= 1'b1;
      slot1_reg    <= 1'b0;
      rd1_reg      <= 1'b0;
      tp1_reg      <= 1'b0;
      tp_byte1_reg <= '0;
    end else begin
      de1_reg      <= de0;
      hs1_reg      <= hs0;
      vs1_reg      <= vs0;
      slot1_reg    <= slot0;
      rd1_reg      <= rd0;
      tp1_reg      <= tp_en;
      tp_byte1_reg <= h_reg[9:2];
    end
  end

  // Stage 1: the popped word is on the FIFO bus now; pixel 0 bypasses the shift register.
  always_comb begin
    pix_byte = shift_reg[31:24];
    pix_ok   = grp_ok_reg;
    if (slot1_reg) begin
      pix_byte = fifo.fifo_data[31:24];
      pix_ok   = rd1_reg;
    end
    if (tp1_reg) begin
      pix_byte = tp_byte1_reg;
      pix_ok   = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      shift_reg  <= '0;
      grp_ok_reg <= 1'b0;
    end else if (slot1_reg) begin
      shift_reg  <= {fifo.fifo_data[23:0], 8'h00};
      grp_ok_reg <= rd1_reg;
    end else begin
      shift_reg  <= {shift_reg[23:0], 8'h00};
    end
  end

  // Stage 2: pin registers; a group that missed its word stays black.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_LCD_HSync <= 1'b1;
      o_LCD_VSync <= 1'b1;
      o_LCD_DE    <= 1'b0;
      o_LCD_R     <= '0;
      o_LCD_G     <= '0;
      o_LCD_B     <= '0;
      o_Underflow <= 1'b0;
    end else begin
      o_LCD_HSync <= hs1_reg;
      o_LCD_VSync <= vs1_reg;
      o_LCD_DE    <= de1_reg;
      o_Underflow <= o_Underflow | underflow0;
      if (de1_reg && pix_ok) begin
        o_LCD_R <= {pix_byte[7:5], pix_byte[7:6]};
        o_LCD_G <= {pix_byte[4:2], pix_byte[4:2]};
        o_LCD_B <= {pix_byte[1:0], pix_byte[1:0], pix_byte[1]};
      end else begin
        o_LCD_R <= '0;
        o_LCD_G <= '0;
        o_LCD_B <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: full 800-pixel lines with a shortened vertical frame (11 lines) so whole
// frames fit in a short run; a per-cycle frame-position model plus directed literal checks.
module tb_lcd_scanout;

  localparam int HA = 800, HFP = 40, HSW = 48, HBP = 88, HT = HA + HFP + HSW + HBP;
  localparam int VA = 4,   VFP = 2,  VSW = 3,  VBP = 2,  VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;

  logic       i_Clk = 1'b0;
  logic       rst_n;
  logic       fdr;
  logic       tp = 1'b0;
  logic       o_hs, o_vs, o_de, o_uf;
  logic [4:0] o_r, o_b;
  logic [5:0] o_g;

  lcd_scanout_if bus ();

  lcd_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP)
  ) dut (
    .i_Clk              (i_Clk),
    .i_Rst_L            (rst_n),
    .i_First_Data_Ready (fdr),
`ifdef LCD_TEST_PATTERN_EN
    .i_Test_Pattern     (tp),
`endif
    .fifo               (bus),
    .o_LCD_HSync        (o_hs),
    .o_LCD_VSync        (o_vs),
    .o_LCD_DE           (o_de),
    .o_LCD_R            (o_r),
    .o_LCD_G            (o_g),
    .o_LCD_B            (o_b),
    .o_Underflow        (o_uf)
  );

  always #5 i_Clk = ~i_Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    if (i == 0) return 32'hE01C03FF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // FIFO behaviour: non-show-ahead, data appears the clock after a pop.
  int fifo_idx = 0;
  initial bus.fifo_data = 32'h0;
  always @(posedge i_Clk) begin
    if (bus.fifo_rd) begin
      bus.fifo_data <= word_of(fifo_idx);
      fifo_idx      <= fifo_idx + 1;
    end
  end

  // Running totals of pin activity, sampled mid-cycle.
  int rd_cnt = 0, de_cnt = 0, hs_lo = 0, vs_lo = 0;
  always @(negedge i_Clk) begin
    rd_cnt += int'(bus.fifo_rd);
    de_cnt += int'(o_de);
    hs_lo  += int'(!o_hs);
    vs_lo  += int'(!o_vs);
  end

  // Reference model: frame position n -> h,v -> regions/word/byte; pins lag by two cycles.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } pin_t;

  localparam pin_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, r: 5'd0, g: 6'd0, b: 5'd0};

  pin_t        p1_m = IDLE, p2_m = IDLE;
  bit          running_m = 1'b0, uf_m = 1'b0, grp_ok_m = 1'b0;
  int          mn_m = 0, pop_m = 0;
  logic [31:0] grp_word_m = 32'h0;

  always @(negedge i_Clk) begin
    pin_t       e;
    int         h, v, k, r3, g3, b2;
    bit         rd_e, uf_ev, ok;
    logic [7:0] px;
    if (!rst_n) begin
      running_m = 1'b0;
      uf_m      = 1'b0;
      p1_m      = IDLE;
      p2_m      = IDLE;
      chk("rst_rd", bus.fifo_rd, 0);
      chk("rst_pins", {o_hs, o_vs, o_de, o_r, o_g, o_b}, IDLE);
      chk("rst_uf", o_uf, 0);
    end else begin
      e = IDLE; rd_e = 1'b0; uf_ev = 1'b0; ok = 1'b0; px = 8'h00;
      if (running_m) begin
        h = mn_m % HT;
        v = (mn_m / HT) % VT;
        k = h % 4;
        e.hs = !(h >= HA + HFP && h < HA + HFP + HSW);
        e.vs = !(v >= VA + VFP && v < VA + VFP + VSW);
        e.de = (h < HA) && (v < VA);
        if (e.de) begin
          if (tp) begin
            px = 8'(h / 4);
            ok = 1'b1;
          end else begin
            if (k == 0) begin
              if (bus.fifo_empty) begin
                grp_ok_m = 1'b0;
                uf_ev    = 1'b1;
              end else begin
                grp_ok_m   = 1'b1;
                grp_word_m = word_of(pop_m);
                pop_m++;
                rd_e = 1'b1;
              end
            end
            px = 8'(grp_word_m >> (24 - 8 * k));
            ok = grp_ok_m;
          end
          if (ok) begin
            r3 = int'(px) / 32; g3 = (int'(px) / 4) % 8; b2 = int'(px) % 4;
            e.r = 5'(r3 * 4 + r3 / 2);
            e.g = 6'(g3 * 8 + g3);
            e.b = 5'(b2 * 8 + b2 * 2 + b2 / 2);
          end
        end
      end
      chk("rd", bus.fifo_rd, rd_e);
      chk("hsync", o_hs, p2_m.hs);
      chk("vsync", o_vs, p2_m.vs);
      chk("de", o_de, p2_m.de);
      chk("rgb", {o_r, o_g, o_b}, {p2_m.r, p2_m.g, p2_m.b});
      chk("underflow", o_uf, uf_m);
      p2_m = p1_m;
      p1_m = e;
      if (uf_ev) uf_m = 1'b1;
      if (running_m) mn_m++;
      else if (fdr) begin
        running_m = 1'b1;
        mn_m      = 0;
      end
    end
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic adv(inout int sn, input int to);
    repeat (to - sn) tick();
    sn = to;
  endtask

  initial begin
    int sn, s_rd, s_de, s_hs, s_vs, f0_rd;
    rst_n = 1'b0; fdr = 1'b0; bus.fifo_empty = 1'b0;
    repeat (5) tick();
    chk("lit_rst_hs", o_hs, 1);
    chk("lit_rst_vs", o_vs, 1);
    chk("lit_rst_de", o_de, 0);
    chk("lit_rst_rd", bus.fifo_rd, 0);
    chk("lit_rst_rgb", {o_r, o_g, o_b}, 0);
    chk("lit_rst_uf", o_uf, 0);

    rst_n = 1'b1;
    s_rd = rd_cnt; s_de = de_cnt;
    repeat (100) tick();
    chk("wait_pops", rd_cnt - s_rd, 0);
    chk("wait_de", de_cnt - s_de, 0);

    // Single-cycle ready pulse: the later deassertion must be ignored.
    fdr = 1'b1;
    tick();
    sn = 0;
    fdr = 1'b0;
    chk("first_rd", bus.fifo_rd, 1);
    s_rd = rd_cnt; s_de = de_cnt; s_hs = hs_lo; f0_rd = rd_cnt;
    adv(sn, 1);  chk("gap_rd", bus.fifo_rd, 0);
    adv(sn, 2);  chk("px0_de", o_de, 1); chk("px0_rgb", {o_r, o_g, o_b}, {5'd31, 6'd0, 5'd0});
    adv(sn, 3);  chk("px1_rgb", {o_r, o_g, o_b}, {5'd0, 6'd63, 5'd0});
    adv(sn, 4);  chk("px2_rgb", {o_r, o_g, o_b}, {5'd0, 6'd0, 5'd31}); chk("rd_h4", bus.fifo_rd, 1);
    adv(sn, 5);  chk("px3_rgb", {o_r, o_g, o_b}, {5'd31, 6'd63, 5'd31});
    adv(sn, 841); chk("hs_before", o_hs, 1);
    adv(sn, 842); chk("hs_first", o_hs, 0);
    adv(sn, 889); chk("hs_last", o_hs, 0);
    adv(sn, 890); chk("hs_after", o_hs, 1);
    adv(sn, HT);
    chk("line_pops", rd_cnt - s_rd, 200);
    chk("line_de", de_cnt - s_de, 800);
    chk("line_hs_lo", hs_lo - s_hs, 48);

    // Empty FIFO at the pop slot of line 1, h=100.
    adv(sn, HT + 100);
    chk("uf_before", o_uf, 0);
    bus.fifo_empty = 1'b1;
    #1;
    chk("uf_no_rd", bus.fifo_rd, 0);
    adv(sn, HT + 101);
    bus.fifo_empty = 1'b0;
    chk("uf_set", o_uf, 1);
    for (int i = 0; i < 4; i++) begin
      adv(sn, HT + 102 + i);
      chk("uf_black_de", o_de, 1);
      chk("uf_black_rgb", {o_r, o_g, o_b}, 0);
      if (i == 2) chk("uf_next_rd", bus.fifo_rd, 1);
    end

    adv(sn, 5857); chk("vs0_before", o_vs, 1);
    adv(sn, 5858); chk("vs0_first", o_vs, 0);
    adv(sn, FRAME);
    chk("frame0_pops", rd_cnt - f0_rd, 4 * 200 - 1);
    s_rd = rd_cnt; s_vs = vs_lo;
    adv(sn, FRAME + 5857); chk("vs1_before", o_vs, 1);
    adv(sn, FRAME + 5858); chk("vs1_first", o_vs, 0);
    adv(sn, FRAME + 8785); chk("vs1_last", o_vs, 0);
    adv(sn, FRAME + 8786); chk("vs1_after", o_vs, 1);
    adv(sn, 2 * FRAME);
    chk("frame1_pops", rd_cnt - s_rd, 4 * 200);
    chk("frame1_vs_lo", vs_lo - s_vs, 3 * HT);
    chk("uf_held", o_uf, 1);

    // Reset in the middle of an active line.
    adv(sn, 2 * FRAME + 3000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hs", o_hs, 1);
    chk("mid_rst_de", o_de, 0);
    chk("mid_rst_rd", bus.fifo_rd, 0);
    chk("mid_rst_uf", o_uf, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    s_rd = rd_cnt; s_de = de_cnt;
    repeat (20) tick();
    chk("rewait_pops", rd_cnt - s_rd, 0);
    chk("rewait_de", de_cnt - s_de, 0);
    fdr = 1'b1;
    tick();
    sn = 0;
    chk("restart_rd", bus.fifo_rd, 1);
    chk("restart_uf", o_uf, 0);
`ifdef LCD_TEST_PATTERN_EN
    adv(sn, HT + 24);
    tp = 1'b1;
    adv(sn, FRAME);
    s_rd = rd_cnt;
    adv(sn, 2 * FRAME);
    chk("tp_pops", rd_cnt - s_rd, 0);
    chk("tp_uf", o_uf, 0);
    tp = 1'b0;
    adv(sn, 2 * FRAME + 100);
`else
    adv(sn, 1000);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
